serial_tx_shifter: RTL and testbench

//  Parallel-in, serial-out frame transmitter: the sending end of a one-wire serial link.
//  The receiving end samples the line bit-by-bit with D flip-flops.

---
 rtl/serial_tx_shifter.sv | 169 ++++++++++++++++
 tb/tb_serial_tx_shifter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_shifter.sv
// serial_tx_shifter: parallel-in, serial-out frame transmitter for a one-wire link.
// Frame = start bit (0), WIDTH data bits MSB-first, optional even parity, stop bit (1).
// The line idles high. Each bit is held on sout for CLKS_PER_BIT clock cycles.
// Optional feature macro: PARITY_EN adds an even-parity bit between data and stop.
module serial_tx_shifter #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             ready,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_clk_cnt;
  logic [BW-1:0]    r_bit_cnt;
  logic [WIDTH-1:0] r_shift;
  logic             r_sout;
  logic             r_busy;
  logic             r_done;

  state_t           w_state_nxt;
  logic [CW-1:0]    w_clk_cnt_nxt;
  logic [BW-1:0]    w_bit_cnt_nxt;
  logic [WIDTH-1:0] w_shift_nxt;
  logic             w_sout_nxt;
  logic             w_bit_end;
  logic             w_accept;

`ifdef PARITY_EN
  logic             r_parity;
`endif

  assign ready     = (r_state == S_IDLE);
  assign w_accept  = ready & load;
  assign w_bit_end = (r_clk_cnt == CLK_LAST);
  assign sout      = r_sout;
  assign busy      = r_busy;
  assign done      = r_done;

  // Next-state, counter, shifter and next-line-value decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_clk_cnt_nxt = r_clk_cnt;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_sout_nxt    = 1'b1;

    // The bit-period counter only runs while a frame is on the line.
    if (r_state != S_IDLE) begin
      w_clk_cnt_nxt = w_bit_end ? '0 : r_clk_cnt + CW'(1);
    end

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt   = S_START;
          w_shift_nxt   = din;
          w_clk_cnt_nxt = '0;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt   = S_DATA;
          w_bit_cnt_nxt = '0;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_bit_cnt == BIT_LAST) begin
`ifdef PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + BW'(1);
            w_shift_nxt   = r_shift << 1;
          end
        end
      end
`ifdef PARITY_EN
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_bit_end) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // sout is registered, so it is decoded from the state being entered.
    case (w_state_nxt)
      S_START:  w_sout_nxt = 1'b0;
      S_DATA:   w_sout_nxt = w_shift_nxt[WIDTH-1];
`ifdef PARITY_EN
      S_PARITY: w_sout_nxt = r_parity;
`endif
      default:  w_sout_nxt = 1'b1;
    endcase
  end

  // State register; reset aborts any frame and forces the line high at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Counters, shift register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_sout    <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_clk_cnt <= w_clk_cnt_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_sout    <= w_sout_nxt;
      r_busy    <= (w_state_nxt != S_IDLE);
      r_done    <= (r_state == S_STOP) && (w_state_nxt == S_IDLE);
    end
  end

`ifdef PARITY_EN
  // Even parity is taken from the word at accept, before shifting destroys it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_parity <= 1'b0;
    end else if (w_accept) begin
      r_parity <= ^din;
    end
  end
`endif

endmodule

// File: tb/tb_serial_tx_shifter.sv
// Testbench for serial_tx_shifter: directed and randomized frames checked cycle by
// cycle against a frame-level reference model (bit list expanded by CLKS_PER_BIT).
module tb_serial_tx_shifter;

  localparam int WIDTH = 8;
  localparam int CPB   = 4;
`ifdef PARITY_EN
  localparam int NBITS = WIDTH + 3;
`else
  localparam int NBITS = WIDTH + 2;
`endif
  localparam int FL = NBITS * CPB;

  logic             clk  = 1'b0;
  logic             rst  = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] din  = '0;
  logic             ready;
  logic             sout;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;

  serial_tx_shifter #(.WIDTH(WIDTH), .CLKS_PER_BIT(CPB)) dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .load (load),
    .ready(ready),
    .sout (sout),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: the frame as a list of line bits, one entry per bit period.
  function automatic logic frame_bit(input logic [WIDTH-1:0] d, input int idx);
    logic q[$];
    q.push_back(1'b0);
    for (int i = WIDTH - 1; i >= 0; i--) q.push_back(d[i]);
`ifdef PARITY_EN
    q.push_back(^d);
`endif
    q.push_back(1'b1);
    return q[idx];
  endfunction

  task automatic start(input logic [WIDTH-1:0] d);
    check("ready_at_load", ready, 1);
    din  = d;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    din  = WIDTH'($urandom);
  endtask

  // Called on the first negedge after the accept edge. Checks every frame cycle
  // and then the done cycle. pulse_at>0 raises load (din=3C) mid-frame for one
  // cycle; abort_at>0 returns unchecked at that cycle.
  task automatic frame(input logic [WIDTH-1:0] d, input int pulse_at, input int abort_at);
    for (int k = 1; k <= FL; k++) begin
      if (k == abort_at) return;
      check($sformatf("sout[%0d] d=%0h", k, d), sout, frame_bit(d, (k - 1) / CPB));
      check($sformatf("busy[%0d]", k), busy, 1);
      check($sformatf("done[%0d]", k), done, 0);
      check($sformatf("ready[%0d]", k), ready, 0);
      if (k == pulse_at) begin
        load = 1'b1;
        din  = 8'h3C;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    load = 1'b0;
    check("done_pulse", done, 1);
    check("busy_done", busy, 0);
    check("ready_done", ready, 1);
    check("sout_done", sout, 1);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      check("idle_sout", sout, 1);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_ready", ready, 1);
      @(negedge clk);
    end
  endtask

  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] nd;

  initial begin
    // Asynchronous reset before any clock edge.
    #1 rst = 1'b1;
    #1;
    check("rst_sout", sout, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", ready, 1);

    // Plain A5 frame.
    start(8'hA5);
    frame(8'hA5, 0, 0);
    idle(3);

    // Mid-frame load pulse with other data is ignored.
    start(8'hA5);
    frame(8'hA5, 15, 0);
    idle(3);

    // Load in the done cycle chains the next frame with no extra gap.
    start(8'hA5);
    frame(8'hA5, 0, 0);
    start(8'h0F);
    frame(8'h0F, 0, 0);
    idle(2);

    // Parity-sensitive word (odd number of ones).
    start(8'h07);
    frame(8'h07, 0, 0);
    idle(2);

    // Reset during the third data bit aborts the frame immediately.
    start(8'h5A);
    frame(8'h5A, 0, 3 * CPB + 2);
    check("pre_abort_sout", sout, 0);
    #1 rst = 1'b1;
    #1;
    check("abort_sout", sout, 1);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_ready", ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(5);
    start(8'h81);
    frame(8'h81, 0, 0);
    idle(2);

    // Randomized frames, random ignored loads, random gaps or back-to-back.
    d = WIDTH'($urandom);
    start(d);
    for (int i = 0; i < 10; i++) begin
      nd = WIDTH'($urandom);
      frame(d, $urandom_range(0, FL - 1), 0);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      start(nd);
      d = nd;
    end
    frame(d, 0, 0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
